// File: rtl/ycbcr_to_rgb_stream.sv
`default_nettype none
// ============================================================================
// Module   : ycbcr_to_rgb_stream
// Purpose  : LANES-wide streaming YCbCr->RGB (BT.601 studio / JFIF full range)
//            with per-block mode latch and last-beat framing.
// Revision : 1.0  initial release
// ============================================================================
module ycbcr_to_rgb_stream #(
  parameter int LANES        = 8,
  parameter int BLOCK_PIXELS = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [LANES*8-1:0] y,
  input  logic [LANES*8-1:0] cb,
  input  logic [LANES*8-1:0] cr,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [LANES*8-1:0] r,
  output logic [LANES*8-1:0] g,
  output logic [LANES*8-1:0] b,
  output logic               last_out
);

  localparam int            BEATS       = BLOCK_PIXELS / LANES;
  localparam int            CW          = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] c_last_beat = CW'(BEATS - 1);

  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    if (v < 18'sd0)   return 8'd0;
    if (v > 18'sd255) return 8'd255;
    return v[7:0];
  endfunction

  logic          w_adv;
  logic          w_accept;
  logic          w_first;
  logic          w_last_tag;
  logic          w_mode_tag;
  logic [CW-1:0] r_count;
  logic          r_mode_lat;
  logic          r_v1, r_v2, r_v3;
  logic          r_m1, r_m2, r_m3;
  logic          r_l1, r_l2, r_l3;

  assign w_adv      = !valid_out || ready_out;
  assign ready_in   = w_adv;
  assign w_accept   = valid_in && w_adv;
  assign w_first    = (r_count == '0);
  assign w_last_tag = (r_count == c_last_beat);
  // The first beat of a block takes the live mode; the rest reuse the latch.
  assign w_mode_tag = w_first ? mode : r_mode_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_mode_lat <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_m1       <= 1'b0;
      r_m2       <= 1'b0;
      r_m3       <= 1'b0;
      r_l1       <= 1'b0;
      r_l2       <= 1'b0;
      r_l3       <= 1'b0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_count <= w_last_tag ? '0 : r_count + 1'b1;
        if (w_first) r_mode_lat <= mode;
      end
      if (w_adv) begin
        r_v1      <= w_accept;
        r_m1      <= w_accept & w_mode_tag;
        r_l1      <= w_accept & w_last_tag;
        r_v2      <= r_v1;
        r_m2      <= r_m1;
        r_l2      <= r_l1;
        r_v3      <= r_v2;
        r_m3      <= r_m2;
        r_l3      <= r_l2;
        valid_out <= r_v3;
        last_out  <= r_l3;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic        [7:0]  r_y, r_cb, r_cr;
    logic signed [17:0] r_py, r_pr, r_pg, r_pb;
    logic signed [17:0] r_sr, r_sg, r_sb;
    logic        [7:0]  r_ro, r_go, r_bo;
    logic        [17:0] w_u_y, w_u_cb, w_u_cr;
    logic signed [17:0] w_dcb, w_dcr;
    logic signed [17:0] w_py, w_pr, w_pg, w_pb;
    logic signed [17:0] w_sr, w_sg, w_sb;

    assign w_u_y  = {10'd0, r_y};
    assign w_u_cb = {10'd0, r_cb};
    assign w_u_cr = {10'd0, r_cr};
    assign w_dcb  = signed'(w_u_cb) - 18'sd128;
    assign w_dcr  = signed'(w_u_cr) - 18'sd128;

    // Products: mode 0 floors each term here; mode 1 keeps the rounding bias
    // in the product and defers the shift to the sum stage.
    always_comb begin
      if (r_m1) begin
        w_py = signed'(w_u_y);
        w_pr = 18'sd359 * w_dcr + 18'sd128;
        w_pg = 18'sd88 * w_dcb + 18'sd183 * w_dcr + 18'sd128;
        w_pb = 18'sd454 * w_dcb + 18'sd128;
      end else begin
        w_py = signed'((18'd298 * w_u_y) >> 8);
        w_pr = signed'((18'd408 * w_u_cr) >> 8);
        w_pg = signed'(((18'd100 * w_u_cb) >> 8) + ((18'd208 * w_u_cr) >> 8));
        w_pb = signed'((18'd516 * w_u_cb) >> 8);
      end
    end

    always_comb begin
      if (r_m2) begin
        w_sr = r_py + (r_pr >>> 8);
        w_sg = r_py - (r_pg >>> 8);
        w_sb = r_py + (r_pb >>> 8);
      end else begin
        w_sr = r_py + r_pr - 18'sd223;
        w_sg = r_py - r_pg + 18'sd136;
        w_sb = r_py + r_pb - 18'sd277;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_y  <= '0;
        r_cb <= '0;
        r_cr <= '0;
        r_py <= '0;
        r_pr <= '0;
        r_pg <= '0;
        r_pb <= '0;
        r_sr <= '0;
        r_sg <= '0;
        r_sb <= '0;
        r_ro <= '0;
        r_go <= '0;
        r_bo <= '0;
      end else if (w_adv) begin
        r_y  <= w_accept ? y[8*i +: 8]  : 8'd0;
        r_cb <= w_accept ? cb[8*i +: 8] : 8'd0;
        r_cr <= w_accept ? cr[8*i +: 8] : 8'd0;
        r_py <= r_v1 ? w_py : '0;
        r_pr <= r_v1 ? w_pr : '0;
        r_pg <= r_v1 ? w_pg : '0;
        r_pb <= r_v1 ? w_pb : '0;
        r_sr <= r_v2 ? w_sr : '0;
        r_sg <= r_v2 ? w_sg : '0;
        r_sb <= r_v2 ? w_sb : '0;
        r_ro <= r_v3 ? clamp8(r_sr) : 8'd0;
        r_go <= r_v3 ? clamp8(r_sg) : 8'd0;
        r_bo <= r_v3 ? clamp8(r_sb) : 8'd0;
      end
    end

    assign r[8*i +: 8] = r_ro;
    assign g[8*i +: 8] = r_go;
    assign b[8*i +: 8] = r_bo;
  end

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_to_rgb_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_ycbcr_to_rgb_stream
// Purpose  : Randomized self-checking bench with arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ycbcr_to_rgb_stream;
  localparam int LANES = 8;
  localparam int BEATS = 64 / LANES;
  localparam int W     = LANES * 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_in;
  logic [W-1:0] y = '0, cb = '0, cr = '0;
  logic         valid_out;
  logic         ready_out = 1'b1;
  logic [W-1:0] r, g, b;
  logic         last_out;

  always #5 clk = ~clk;

  ycbcr_to_rgb_stream #(.LANES(LANES), .BLOCK_PIXELS(64)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .valid_in(valid_in),
    .ready_in(ready_in), .y(y), .cb(cb), .cr(cr), .valid_out(valid_out),
    .ready_out(ready_out), .r(r), .g(g), .b(b), .last_out(last_out)
  );

  typedef struct {
    logic [W-1:0] r, g, b;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_last   = 0;
  int   bc       = 0;
  logic bm       = 1'b0;

  function automatic int clip(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic logic [23:0] ref_pix(input int yv, input int cbv, input int crv, input logic m);
    int rv, gv, bv, yp, dcb, dcr;
    if (!m) begin
      yp = (298 * yv) / 256;
      rv = yp + (408 * crv) / 256 - 223;
      gv = yp - (100 * cbv) / 256 - (208 * crv) / 256 + 136;
      bv = yp + (516 * cbv) / 256 - 277;
    end else begin
      dcb = cbv - 128;
      dcr = crv - 128;
      rv = yv + ((359 * dcr + 128) >>> 8);
      gv = yv - ((88 * dcb + 183 * dcr + 128) >>> 8);
      bv = yv + ((454 * dcb + 128) >>> 8);
    end
    return {8'(clip(rv)), 8'(clip(gv)), 8'(clip(bv))};
  endfunction

  // Scoreboard: model each accepted beat, compare each transferred output beat.
  always @(negedge clk) begin : scoreboard
    exp_t        e;
    exp_t        got;
    logic [23:0] px;
    if (rst_n) begin
      if (valid_out && ready_out) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got valid_out=1 r=%h, required no output", r);
        end else begin
          e = exp_q.pop_front();
          if ({r, g, b, last_out} !== {e.r, e.g, e.b, e.last}) begin
            n_fail++;
            $display("FAIL scoreboard_beat: got r=%h g=%h b=%h last=%b, required r=%h g=%h b=%h last=%b",
                     r, g, b, last_out, e.r, e.g, e.b, e.last);
          end
        end
        if (last_out) n_last++;
      end
      if (valid_in && ready_in) begin
        if (bc == 0) bm = mode;
        got.last = (bc == BEATS - 1);
        for (int i = 0; i < LANES; i++) begin
          px = ref_pix(int'(y[8*i +: 8]), int'(cb[8*i +: 8]), int'(cr[8*i +: 8]), bm);
          got.r[8*i +: 8] = px[23:16];
          got.g[8*i +: 8] = px[15:8];
          got.b[8*i +: 8] = px[7:0];
        end
        exp_q.push_back(got);
        bc = (bc + 1) % BEATS;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] yv, input logic [W-1:0] cbv,
                            input logic [W-1:0] crv, input logic m);
    int   t;
    logic acc;
    t = 0;
    acc = 1'b0;
    y = yv; cb = cbv; cr = crv; mode = m; valid_in = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got ready_in=0 for %0d cycles, required acceptance", t);
    end
  endtask

  task automatic idle();
    valid_in = 1'b0;
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    while (!valid_out && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!valid_out) begin
      n_checks++;
      n_fail++;
      $display("FAIL output_timeout: got valid_out=0, required 1");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({valid_out, last_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got valid_out=%b last_out=%b, required 0 0", valid_out, last_out);
    end
    n_checks++;
    if ({r, g, b} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got r=%h g=%h b=%h, required 0", r, g, b);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ready_in !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got ready_in=%b, required 1", ready_in);
    end
  endtask

  task automatic test_grey_latency();
    int lat;
    drive_beat({LANES{8'd128}}, {LANES{8'd128}}, {LANES{8'd128}}, 1'b1);
    idle();
    lat = 0;
    while (!valid_out && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL grey_latency: got %0d cycles, required 3", lat);
    end
    n_checks++;
    if ({r, g, b} !== {{LANES{8'd128}}, {LANES{8'd128}}, {LANES{8'd128}}}) begin
      n_fail++;
      $display("FAIL grey_value: got r=%h g=%h b=%h, required all 80", r, g, b);
    end
  endtask

  // Second beat of the grey block: mode input 0 must be ignored mid-block.
  task automatic test_saturation();
    drive_beat({LANES{8'd255}}, {LANES{8'd128}}, {LANES{8'd255}}, 1'b0);
    idle();
    wait_out();
    n_checks++;
    if ({r, g, b} !== {{LANES{8'd255}}, {LANES{8'd164}}, {LANES{8'd255}}}) begin
      n_fail++;
      $display("FAIL saturation: got r=%h g=%h b=%h, required ff/a4/ff", r, g, b);
    end
    for (int k = 0; k < BEATS - 2; k++) drive_beat(rand_vec(), rand_vec(), rand_vec(), 1'($urandom_range(0, 1)));
    idle();
    drain();
  endtask

  task automatic test_mode0_black_white();
    drive_beat({LANES{8'd16}}, {LANES{8'd128}}, {LANES{8'd128}}, 1'b0);
    drive_beat({LANES{8'd235}}, {LANES{8'd128}}, {LANES{8'd128}}, 1'b1);
    idle();
    wait_out();
    n_checks++;
    if ({r, g, b} !== '0) begin
      n_fail++;
      $display("FAIL mode0_black: got r=%h g=%h b=%h, required 0", r, g, b);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({valid_out, r, g, b} !== {1'b1, {LANES{8'd254}}, {LANES{8'd255}}, {LANES{8'd254}}}) begin
      n_fail++;
      $display("FAIL mode0_white: got v=%b r=%h g=%h b=%h, required 1 fe/ff/fe", valid_out, r, g, b);
    end
    for (int k = 0; k < BEATS - 2; k++) drive_beat(rand_vec(), rand_vec(), rand_vec(), 1'($urandom_range(0, 1)));
    idle();
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 5 * BEATS; k++) begin
      drive_beat(rand_vec(), rand_vec(), rand_vec(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();
    drain();
  endtask

  task automatic test_block_framing();
    int n0;
    n0 = n_last;
    for (int k = 0; k < 2 * BEATS; k++) drive_beat(rand_vec(), rand_vec(), rand_vec(), 1'(k >= 3));
    idle();
    drain();
    n_checks++;
    if (n_last - n0 != 2) begin
      n_fail++;
      $display("FAIL framing_last_count: got %0d, required 2", n_last - n0);
    end
  endtask

  task automatic test_backpressure();
    fork
      begin
        logic [W-1:0] tag;
        for (int k = 0; k < 2 * BEATS; k++) begin
          tag = rand_vec();
          tag[7:0] = 8'(k);
          drive_beat(tag, rand_vec(), rand_vec(), 1'($urandom_range(0, 1)));
        end
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        ready_out = 1'b0;
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (ready_in !== 1'b0 || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_handshake: got ready_in=%b valid_out=%b, required 0 1", ready_in, valid_out);
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL stall_hold: got empty model queue, required a held beat");
          end else if ({r, g, b, last_out} !== {exp_q[0].r, exp_q[0].g, exp_q[0].b, exp_q[0].last}) begin
            n_fail++;
            $display("FAIL stall_hold: got r=%h g=%h b=%h, required r=%h g=%h b=%h",
                     r, g, b, exp_q[0].r, exp_q[0].g, exp_q[0].b);
          end
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_midblock();
    int n0;
    for (int k = 0; k < 3; k++) drive_beat({LANES{8'd200}}, {LANES{8'd100}}, {LANES{8'd220}}, 1'b1);
    idle();
    ready_out = 1'b0;
    wait_out();
    #2;
    n_checks++;
    if (valid_out !== 1'b1 || r === '0) begin
      n_fail++;
      $display("FAIL pre_reset_output: got valid_out=%b r=%h, required held nonzero beat", valid_out, r);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid_out, last_out} !== 2'b00 || {r, g, b} !== '0) begin
      n_fail++;
      $display("FAIL midblock_reset: got v=%b last=%b r=%h g=%h b=%h, required all 0",
               valid_out, last_out, r, g, b);
    end
    exp_q.delete();
    bc = 0;
    bm = 1'b0;
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_last;
    for (int k = 0; k < BEATS; k++) drive_beat(rand_vec(), rand_vec(), rand_vec(), 1'($urandom_range(0, 1)));
    idle();
    drain();
    n_checks++;
    if (n_last - n0 != 1) begin
      n_fail++;
      $display("FAIL post_reset_framing: got %0d last beats, required 1", n_last - n0);
    end
  endtask

  initial begin
    test_reset();
    test_grey_latency();
    test_saturation();
    test_mode0_black_white();
    test_random();
    test_block_framing();
    test_backpressure();
    test_reset_midblock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
